galaga_key_ctrl: RTL and testbench

Converts the 16-bit USB HID keycode word that the NIOS II system exports (two 8-bit usage codes) into registered Galaga player controls. Sits directly downstream of the Qsys system's `keycode_export`, and feeds the ship-movement and missile-spawn logic. Provides press-edge detection, most-recent-wins left/right arbitration, a pause toggle, and frame-paced fire with cooldown.

---
 rtl/galaga_key_ctrl.sv | 146 ++++++++++++++
 tb/tb_galaga_key_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/galaga_key_ctrl.sv
// Galaga player controls decoded from the two-byte USB HID keycode word.
// Define GALAGA_AUTOFIRE_EN to re-arm fire on every frame tick while Space is held.
//
// Fire FSM
//   state     | meaning
//   FIRE_IDLE | no shot requested
//   FIRE_PEND | shot requested, waiting for a frame tick with cooldown expired
module galaga_key_ctrl #(
    parameter int unsigned FIRE_COOLDOWN = 8
) (
    input  logic        clk_clk,
    input  logic        reset_reset_n,
    input  logic [15:0] keycode,
    input  logic        frame_tick,
    output logic        move_left,
    output logic        move_right,
    output logic        fire_pulse,
    output logic        start_pulse,
    output logic        paused
);

    localparam logic [3:0] CD_LOAD = 4'(FIRE_COOLDOWN);

    // held / press bit positions
    localparam int H_LEFT  = 0;
    localparam int H_RIGHT = 1;
    localparam int H_FIRE  = 2;
    localparam int H_PAUSE = 3;
    localparam int H_START = 4;

    typedef enum logic {
        FIRE_IDLE = 1'b0,
        FIRE_PEND = 1'b1
    } fire_state_t;

    logic [15:0] k_q;
    logic [4:0]  held_d, held_q, held_prev_q, press;
    logic        last_dir_d, last_dir_q;
    logic        paused_d, paused_q;
    logic        move_left_d, move_left_q;
    logic        move_right_d, move_right_q;
    logic        start_pulse_d, start_pulse_q;
    logic        fire_pulse_d, fire_pulse_q;
    logic [3:0]  cd_d, cd_q;
    logic        issue;
    fire_state_t fire_state_d, fire_state_q;

    function automatic logic key_is(input logic [15:0] kc, input logic [7:0] code);
        return (kc[7:0] == code) || (kc[15:8] == code);
    endfunction

    assign held_d[H_LEFT]  = key_is(k_q, 8'h04) || key_is(k_q, 8'h50);
    assign held_d[H_RIGHT] = key_is(k_q, 8'h07) || key_is(k_q, 8'h4F);
    assign held_d[H_FIRE]  = key_is(k_q, 8'h2C);
    assign held_d[H_PAUSE] = key_is(k_q, 8'h13);
    assign held_d[H_START] = key_is(k_q, 8'h28);

    assign press = held_q & ~held_prev_q;

    // last_dir: 1 = right; a simultaneous left/right press resolves to right
    always_comb begin
        last_dir_d    = last_dir_q;
        move_left_d   = 1'b0;
        move_right_d  = 1'b0;
        paused_d      = paused_q ^ press[H_PAUSE];
        start_pulse_d = press[H_START];
        if (press[H_RIGHT]) begin
            last_dir_d = 1'b1;
        end else if (press[H_LEFT]) begin
            last_dir_d = 1'b0;
        end
        if (!paused_d) begin
            case ({held_q[H_RIGHT], held_q[H_LEFT]})
                2'b01:   move_left_d  = 1'b1;
                2'b10:   move_right_d = 1'b1;
                2'b11: begin
                    move_right_d = last_dir_d;
                    move_left_d  = ~last_dir_d;
                end
                default: ;
            endcase
        end
    end

    assign issue = frame_tick && (fire_state_q == FIRE_PEND) && (cd_q == 4'd0) && !paused_q;

    always_comb begin
        fire_state_d = fire_state_q;
        fire_pulse_d = issue;
        cd_d         = cd_q;
        if (issue) begin
            cd_d = CD_LOAD;
        end else if (frame_tick && (cd_q != 4'd0)) begin
            cd_d = cd_q - 4'd1;
        end
        if (paused_q) begin
            fire_state_d = FIRE_IDLE;
        end else begin
            case (fire_state_q)
                FIRE_IDLE: if (press[H_FIRE]) fire_state_d = FIRE_PEND;
                FIRE_PEND: if (issue && !press[H_FIRE]) fire_state_d = FIRE_IDLE;
                default:   fire_state_d = FIRE_IDLE;
            endcase
`ifdef GALAGA_AUTOFIRE_EN
            if (frame_tick && (cd_q == 4'd0) && held_q[H_FIRE]) begin
                fire_state_d = FIRE_PEND;
            end
`endif
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            k_q           <= 16'h0000;
            held_q        <= 5'b0;
            held_prev_q   <= 5'b0;
            last_dir_q    <= 1'b0;
            paused_q      <= 1'b0;
            move_left_q   <= 1'b0;
            move_right_q  <= 1'b0;
            start_pulse_q <= 1'b0;
            fire_pulse_q  <= 1'b0;
            cd_q          <= 4'd0;
            fire_state_q  <= FIRE_IDLE;
        end else begin
            k_q           <= keycode;
            held_q        <= held_d;
            held_prev_q   <= held_q;
            last_dir_q    <= last_dir_d;
            paused_q      <= paused_d;
            move_left_q   <= move_left_d;
            move_right_q  <= move_right_d;
            start_pulse_q <= start_pulse_d;
            fire_pulse_q  <= fire_pulse_d;
            cd_q          <= cd_d;
            fire_state_q  <= fire_state_d;
        end
    end

    assign move_left   = move_left_q;
    assign move_right  = move_right_q;
    assign fire_pulse  = fire_pulse_q;
    assign start_pulse = start_pulse_q;
    assign paused      = paused_q;

endmodule

// File: tb/tb_galaga_key_ctrl.sv
// Bench for galaga_key_ctrl: directed scenarios plus random keycode traffic,
// all checked against a timestamp-based reference model of the key controls.
module tb_galaga_key_ctrl;

    localparam int CD = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] kc = 16'h0000;
    logic        tick = 1'b0;
    logic        move_left, move_right, fire_pulse, start_pulse, paused;

    always #5 clk = ~clk;

    galaga_key_ctrl #(.FIRE_COOLDOWN(CD)) dut (
        .clk_clk       (clk),
        .reset_reset_n (rst_n),
        .keycode       (kc),
        .frame_tick    (tick),
        .move_left     (move_left),
        .move_right    (move_right),
        .fire_pulse    (fire_pulse),
        .start_pulse   (start_pulse),
        .paused        (paused)
    );

    int vecs = 0;
    int errs = 0;

    // key map: code -> function (0 left, 1 right, 2 fire, 3 pause, 4 start)
    logic [7:0] map_code [7] = '{8'h04, 8'h50, 8'h07, 8'h4F, 8'h2C, 8'h13, 8'h28};
    int         map_fn   [7] = '{0, 0, 1, 1, 2, 3, 4};

    // reference model state
    logic [15:0] kh [3];
    int          cyc, tl, tr, m_cd;
    logic        m_paused, m_pend, m_ml, m_mr, m_fp, m_sp;

    logic [4:0] dut_v, mod_v;
    assign dut_v = {move_left, move_right, fire_pulse, start_pulse, paused};
    assign mod_v = {m_ml, m_mr, m_fp, m_sp, m_paused};

    function automatic logic [4:0] funcs_held(input logic [15:0] v);
        logic [4:0] r = 5'b0;
        for (int i = 0; i < 7; i++)
            if (v[7:0] == map_code[i] || v[15:8] == map_code[i]) r[map_fn[i]] = 1'b1;
        return r;
    endfunction

    // drive one cycle of inputs, advance the model across the edge, settle
    task automatic step(input logic [15:0] k, input logic t);
        logic [4:0] h, hp, pr;
        logic       iss, np, npd;
        int         nc;
        kc   = k;
        tick = t;
        @(posedge clk);
        if (!rst_n) begin
            kh = '{default: 16'h0};
            cyc = 0; tl = 0; tr = -1; m_cd = 0;
            m_paused = 0; m_pend = 0; m_ml = 0; m_mr = 0; m_fp = 0; m_sp = 0;
        end else begin
            h  = funcs_held(kh[1]);
            hp = funcs_held(kh[2]);
            pr = h & ~hp;
            cyc++;
            if (pr[0]) tl = cyc;
            if (pr[1]) tr = cyc;
            iss  = t && m_pend && (m_cd == 0) && !m_paused;
            np   = m_paused ^ pr[3];
            m_ml = !np && h[0] && (!h[1] || tl > tr);
            m_mr = !np && h[1] && (!h[0] || tr >= tl);
            m_sp = pr[4];
            m_fp = iss;
            nc   = iss ? CD : ((t && m_cd > 0) ? m_cd - 1 : m_cd);
            npd  = m_paused ? 1'b0 : (iss ? pr[2] : (m_pend | pr[2]));
`ifdef GALAGA_AUTOFIRE_EN
            if (!m_paused && t && m_cd == 0 && h[2]) npd = 1'b1;
`endif
            m_paused = np; m_cd = nc; m_pend = npd;
            kh[2] = kh[1]; kh[1] = kh[0]; kh[0] = k;
        end
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step(16'h2C04, 1'b0);
            vecs++;
            if (dut_v !== 5'b0) begin errs++; $display("FAIL reset_outputs: got %b want 00000", dut_v); end
        end
        rst_n = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            step(16'h2C04, 1'b0);
            vecs++;
            if (dut_v !== mod_v) begin errs++; $display("FAIL reset_model: got %b want %b", dut_v, mod_v); end
        end
        vecs++;
        if (move_left !== 1'b1) begin errs++; $display("FAIL reset_left_3cyc: got %b want 1", move_left); end
        step(16'h2C04, 1'b1);
        vecs++;
        if (fire_pulse !== 1'b1) begin errs++; $display("FAIL reset_fire: got %b want 1", fire_pulse); end
        step(16'h2C04, 1'b0);
        vecs++;
        if (fire_pulse !== 1'b0) begin errs++; $display("FAIL reset_fire_width: got %b want 0", fire_pulse); end
        for (int i = 0; i < 4; i++) step(16'h0000, 1'b0);
    endtask

    task automatic test_arbitration;
        logic [15:0] seq [4] = '{16'h0004, 16'h0704, 16'h0007, 16'h0000};
        logic [1:0]  want [4] = '{2'b10, 2'b01, 2'b01, 2'b00};
        for (int s = 0; s < 4; s++) begin
            for (int i = 0; i < 4; i++) begin
                step(seq[s], 1'b0);
                vecs++;
                if (dut_v !== mod_v) begin errs++; $display("FAIL arb_model: got %b want %b", dut_v, mod_v); end
            end
            vecs++;
            if ({move_left, move_right} !== want[s])
                begin errs++; $display("FAIL arb_dir kc=%h: got %b want %b", seq[s], {move_left, move_right}, want[s]); end
        end
    endtask

    task automatic test_cooldown;
        int ntick = 0, p1 = -1, p2 = -1, rc = 0;
        logic [15:0] k;
        for (int i = 0; i < 12; i++) step(16'h0000, (i % 3) == 0);
        for (int c = 0; c < 80; c++) begin
            k = (c < 4 || (p1 >= 0 && rc < 4)) ? 16'h002C : 16'h0000;
            if (p1 >= 0) rc++;
            if (c % 3 == 2) ntick++;
            step(k, (c % 3) == 2);
            vecs++;
            if (dut_v !== mod_v) begin errs++; $display("FAIL cool_model: got %b want %b", dut_v, mod_v); end
            if (fire_pulse === 1'b1) begin
                if (p1 < 0) p1 = ntick;
                else if (p2 < 0) p2 = ntick;
            end
        end
        vecs++;
        if (p1 < 0 || p2 < 0 || (p2 - p1) !== CD + 1)
            begin errs++; $display("FAIL cool_gap: got %0d ticks want %0d", p2 - p1, CD + 1); end
    endtask

    task automatic test_pause;
        for (int i = 0; i < 12; i++) step(16'h0000, (i % 2) == 0);
        for (int i = 0; i < 8; i++) step(i < 4 ? 16'h0013 : 16'h0000, 1'b0);
        vecs++;
        if (paused !== 1'b1) begin errs++; $display("FAIL pause_on: got %b want 1", paused); end
        for (int i = 0; i < 12; i++) begin
            step(16'h2C04, (i % 2) == 1);
            vecs++;
            if ({move_left, move_right, fire_pulse} !== 3'b000 || dut_v !== mod_v)
                begin errs++; $display("FAIL pause_hold: got %b want %b", dut_v, mod_v); end
        end
        for (int i = 0; i < 24; i++) begin
            step(i < 4 ? 16'h1304 : 16'h0004, (i % 2) == 1);
            vecs++;
            if (fire_pulse !== 1'b0 || dut_v !== mod_v)
                begin errs++; $display("FAIL pause_release: got %b want %b", dut_v, mod_v); end
        end
        vecs++;
        if ({paused, move_left} !== 2'b01) begin errs++; $display("FAIL pause_off: got %b want 01", {paused, move_left}); end
        for (int i = 0; i < 4; i++) step(16'h0000, 1'b0);
    endtask

    task automatic test_simultaneous;
        int ntick = 0, pulses = 0, gap = -1;
        logic [15:0] ks [9] = '{16'h002C, 16'h002C, 16'h002C, 16'h0, 16'h0, 16'h0,
                                16'h002C, 16'h002C, 16'h002C};
        for (int i = 0; i < 16; i++) step(16'h0000, (i % 2) == 0);
        for (int i = 0; i < 9; i++) begin
            step(ks[i], i == 8);
            vecs++;
            if (dut_v !== mod_v) begin errs++; $display("FAIL simul_model: got %b want %b", dut_v, mod_v); end
        end
        vecs++;
        if (fire_pulse !== 1'b1) begin errs++; $display("FAIL simul_issue: got %b want 1", fire_pulse); end
        for (int i = 0; i < 30; i++) begin
            if (i % 2 == 1) ntick++;
            step(16'h0000, (i % 2) == 1);
            vecs++;
            if (dut_v !== mod_v) begin errs++; $display("FAIL simul_model2: got %b want %b", dut_v, mod_v); end
            if (fire_pulse === 1'b1) begin pulses++; if (gap < 0) gap = ntick; end
        end
        vecs++;
        if (pulses !== 1 || gap !== CD + 1)
            begin errs++; $display("FAIL simul_second: got %0d pulses gap %0d want 1 gap %0d", pulses, gap, CD + 1); end
    endtask

    task automatic test_autofire;
        int pulses = 0, want;
`ifdef GALAGA_AUTOFIRE_EN
        want = (20 - 1) / (CD + 1) + 1;
`else
        want = 1;
`endif
        for (int i = 0; i < 16; i++) step(16'h0000, (i % 2) == 0);
        for (int i = 0; i < 44; i++) begin
            step(16'h002C, i >= 4 && (i % 2) == 1);
            vecs++;
            if (dut_v !== mod_v) begin errs++; $display("FAIL auto_model: got %b want %b", dut_v, mod_v); end
            if (fire_pulse === 1'b1) pulses++;
        end
        for (int i = 0; i < 10; i++) begin
            step(16'h0000, 1'b0);
            if (fire_pulse === 1'b1) pulses++;
        end
        vecs++;
        if (pulses !== want) begin errs++; $display("FAIL auto_count: got %0d want %0d", pulses, want); end
    endtask

    task automatic test_random;
        logic [7:0]  pool [10] = '{8'h00, 8'h00, 8'h04, 8'h50, 8'h07, 8'h4F, 8'h2C, 8'h13, 8'h28, 8'h00};
        logic [15:0] k = 16'h0;
        int          hold = 0;
        for (int c = 0; c < 900; c++) begin
            if (hold == 0) begin
                k[7:0]  = pool[$urandom_range(0, 9)];
                k[15:8] = ($urandom_range(0, 9) == 9) ? 8'($urandom) : pool[$urandom_range(0, 9)];
                hold    = $urandom_range(1, 6);
            end
            hold--;
            rst_n = ($urandom_range(0, 299) != 0);
            step(k, $urandom_range(0, 3) == 0);
            rst_n = 1'b1;
            vecs++;
            if (dut_v !== mod_v || (move_left && move_right))
                begin errs++; $display("FAIL random c=%0d kc=%h: got %b want %b", c, k, dut_v, mod_v); end
        end
    endtask

    initial begin
        test_reset();
        test_arbitration();
        test_cooldown();
        test_pause();
        test_simultaneous();
        test_autofire();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
